// File: rtl/midi_pkg.sv
// Shared MIDI definitions: receiver state encoding, line-rate constants and the
// 2-of-3 vote used when MIDI_UART_RX_MAJORITY_EN is defined.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int MIDI_BAUD            = 31250;
  localparam int SYS_CLK_HZ           = 100_000_000;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / MIDI_BAUD;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// Show-ahead receive FIFO. A push into a full FIFO still lands when the head is
// popped in the same cycle; otherwise it is dropped and flagged on drop_o.
module midi_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          pop;
  logic          accept;

  assign valid_o = (fill_q != '0);
  assign full_o  = (fill_q == FW'(DEPTH));
  assign pop     = pop_i && valid_o;
  assign accept  = push_i && (!full_o || pop);
  assign drop_o  = push_i && full_o && !pop;
  // Storage is not reset, so the head is forced to zero whenever nothing is queued.
  assign data_o  = valid_o ? mem_q[rd_q] : 8'h00;
  assign fill_o  = fill_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q + FW'(accept) - FW'(pop);
    if (accept) wr_d = wr_q + 1'b1;
    if (pop)    rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: synchroniser, bit-centre framer and receive FIFO.
// Optional macro MIDI_UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          MIDI_RX,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          framing_err,
  output logic                          overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
`ifdef MIDI_UART_RX_MAJORITY_EN
  // Start decision waits one extra cycle for the trailing vote sample; every later
  // decision inherits that offset through the timer restart.
  localparam logic [TW-1:0] START_AT = TW'(HALF);
`else
  localparam logic [TW-1:0] START_AT = TW'(HALF - 1);
`endif

  logic          sync_meta_q;
  logic          rxs_q;
  logic          sample_bit;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          fe_d;
  logic          framing_err_q;
  logic          overrun_q;
  logic          fifo_drop;
  logic          fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b1;
      rxs_q       <= 1'b1;
    end else begin
      sync_meta_q <= MIDI_RX;
      rxs_q       <= sync_meta_q;
    end
  end

`ifdef MIDI_UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rxs_q};
  end

  assign sample_bit = majority3(hist_q[1], hist_q[0], rxs_q);
`else
  assign sample_bit = rxs_q;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (timer_q == START_AT) begin
          timer_d = '0;
          if (sample_bit) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d   = '0;
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (sample_bit) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // A low stop bit usually means a line break; hold here until the line idles.
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      bit_idx_q     <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      framing_err_q <= fe_d;
      overrun_q     <= fifo_drop;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  midi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (m_ready),
    .data_o  (m_data),
    .valid_o (m_valid),
    .full_o  (fifo_full),
    .fill_o  (fill),
    .drop_o  (fifo_drop)
  );

  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: table of frames, hand-written corner
// sequences and a randomized run scored against a byte-queue model.
module tb_midi_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int FD   = 4;
`ifdef MIDI_UART_RX_MAJORITY_EN
  localparam int MAJ  = 1;
`else
  localparam int MAJ  = 0;
`endif
  // Pin edge to m_valid rise, in clock edges.
  localparam int LAT  = 3 + HALF + 9 * CPB + MAJ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       MIDI_RX = 1'b1;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] fill;
  logic       framing_err;
  logic       overrun;

  midi_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MIDI_RX     (MIDI_RX),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .fill        (fill),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rxq[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_cyc = 0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (m_valid && !prev_v) rise_cyc <= cyc;
      prev_v <= m_valid;
      if (m_valid && m_ready) rxq.push_back(m_data);
      if (framing_err) fe_cnt <= fe_cnt + 1;
      if (overrun)     ov_cnt <= ov_cnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame; glitch_bit >= 0 puts a one-cycle high pulse at that bit's centre.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
    MIDI_RX   = 1'b0;
    start_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        MIDI_RX = d[i];
        tick(HALF);
        MIDI_RX = 1'b1;
        tick(1);
        MIDI_RX = d[i];
        tick(CPB - HALF - 1);
      end else begin
        MIDI_RX = d[i];
        tick(CPB);
      end
    end
    MIDI_RX = stop;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_push;
    int         exp_fe;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exp_q[$];
  int         rb, fb, ob, exp_fe;
  logic [7:0] rd;
  logic       bad;

  initial begin
    tbl[0] = '{8'h90, 1'b1, 4,  1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 0,  1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 7,  1'b1, 0};
    tbl[3] = '{8'h55, 1'b0, 3,  1'b0, 1};
    tbl[4] = '{8'hAA, 1'b1, 2,  1'b1, 0};
    tbl[5] = '{8'h7F, 1'b1, 10, 1'b1, 0};

    rst_n = 1'b0;
    tick(3);
    check("reset m_valid", 32'(m_valid), 0);
    check("reset m_data", 32'(m_data), 0);
    check("reset fill", 32'(fill), 0);
    check("reset framing_err", 32'(framing_err), 0);
    check("reset overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    tick(5);

    m_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      rb = rxq.size(); fb = fe_cnt; ob = ov_cnt;
      send_frame(tbl[v].data, tbl[v].stop, -1);
      if (!tbl[v].stop) begin
        tick(3 * CPB);
        MIDI_RX = 1'b1;
      end
      tick(tbl[v].gap + 4);
      check($sformatf("vec%0d count", v), 32'(rxq.size() - rb), 32'(tbl[v].exp_push));
      if (tbl[v].exp_push && rxq.size() > rb) begin
        check($sformatf("vec%0d data", v), 32'(rxq[rb]), 32'(tbl[v].data));
        check($sformatf("vec%0d latency", v), 32'(rise_cyc), 32'(start_cyc + LAT));
      end
      check($sformatf("vec%0d framing_err", v), 32'(fe_cnt - fb), 32'(tbl[v].exp_fe));
      check($sformatf("vec%0d overrun", v), 32'(ov_cnt - ob), 0);
    end

    // Short start glitch is rejected silently.
    rb = rxq.size(); fb = fe_cnt; ob = ov_cnt;
    MIDI_RX = 1'b0;
    tick(5);
    MIDI_RX = 1'b1;
    tick(40);
    check("glitch count", 32'(rxq.size() - rb), 0);
    check("glitch framing_err", 32'(fe_cnt - fb), 0);
    check("glitch overrun", 32'(ov_cnt - ob), 0);
    send_frame(8'h5A, 1'b1, -1);
    tick(4);
    check("post-glitch count", 32'(rxq.size() - rb), 1);
    if (rxq.size() > rb) check("post-glitch data", 32'(rxq[rb]), 32'h5A);

    // Bad stop, long break, then a clean byte.
    rb = rxq.size(); fb = fe_cnt; ob = ov_cnt;
    send_frame(8'h3C, 1'b0, -1);
    tick(100);
    MIDI_RX = 1'b1;
    tick(20);
    send_frame(8'h45, 1'b1, -1);
    tick(4);
    check("break framing_err", 32'(fe_cnt - fb), 1);
    check("break count", 32'(rxq.size() - rb), 1);
    if (rxq.size() > rb) check("break data", 32'(rxq[rb]), 32'h45);

    // Fill the FIFO and overflow it by one.
    m_ready = 1'b0;
    rb = rxq.size(); ob = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1);
      tick(4);
    end
    check("full fill", 32'(fill), FD);
    check("full overrun", 32'(ov_cnt - ob), 1);
    check("full m_valid", 32'(m_valid), 1);
    check("full head", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    tick(10);
    check("drain count", 32'(rxq.size() - rb), 4);
    for (int i = 0; i < 4; i++)
      if (rxq.size() > rb + i) check($sformatf("drain[%0d]", i), 32'(rxq[rb + i]), 32'(i + 1));
    check("drain fill", 32'(fill), 0);

    // Reset mid-frame with a byte waiting in the FIFO.
    m_ready = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    tick(4);
    check("pre-reset m_valid", 32'(m_valid), 1);
    MIDI_RX = 1'b0;
    tick(CPB);
    MIDI_RX = 1'b1;
    tick(4 * CPB + HALF);
    rst_n = 1'b0;
    tick(2);
    check("midreset m_valid", 32'(m_valid), 0);
    check("midreset m_data", 32'(m_data), 0);
    check("midreset fill", 32'(fill), 0);
    check("midreset framing_err", 32'(framing_err), 0);
    check("midreset overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    tick(6 * CPB);
    check("post-reset idle", 32'(m_valid), 0);
    m_ready = 1'b1;
    rb = rxq.size();
    send_frame(8'hA5, 1'b1, -1);
    tick(4);
    check("post-reset count", 32'(rxq.size() - rb), 1);
    if (rxq.size() > rb) check("post-reset data", 32'(rxq[rb]), 32'hA5);

    // One-cycle high pulse at the bit-2 centre of 0x00.
    rb = rxq.size();
    send_frame(8'h00, 1'b1, 2);
    tick(4);
    check("centre-glitch count", 32'(rxq.size() - rb), 1);
    if (rxq.size() > rb) check("centre-glitch data", 32'(rxq[rb]), (MAJ != 0) ? 32'h00 : 32'h04);

    // Randomized frames, gaps, stop errors and consumer stalls.
    rb = rxq.size(); fb = fe_cnt; ob = ov_cnt; exp_fe = 0;
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rd  = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_frame(rd, !bad, -1);
      if (bad) begin
        tick($urandom_range(1, 3) * CPB);
        MIDI_RX = 1'b1;
        tick(2);
        exp_fe++;
      end else begin
        exp_q.push_back(rd);
      end
      tick($urandom_range(0, 12));
    end
    rand_rdy = 1'b0;
    m_ready  = 1'b1;
    tick(20);
    check("random count", 32'(rxq.size() - rb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (rxq.size() > rb + i) check($sformatf("random[%0d]", i), 32'(rxq[rb + i]), 32'(exp_q[i]));
    check("random framing_err", 32'(fe_cnt - fb), 32'(exp_fe));
    check("random overrun", 32'(ov_cnt - ob), 0);
    check("random final fill", 32'(fill), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
